// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction FIFO carrying PC, instruction and branch-predictor state.
// Optional FETCH_BUFFER_BYPASS_EN forwards a push straight to the pop side when the buffer is empty.
module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [XLEN-1:0]         push_pc,
    input  logic [XLEN-1:0]         push_instr,
    input  logic [1:0]              push_bp_state,
    input  logic                    push_pred_taken,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [XLEN-1:0]         pop_pc,
    output logic [XLEN-1:0]         pop_instr,
    output logic [1:0]              pop_bp_state,
    output logic                    pop_pred_taken,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = 2 * XLEN + 3;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ENT_W-1:0] push_entry;
    logic [ENT_W-1:0] head_sel;
    logic [ENT_W-1:0] pop_entry;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             do_push;
    logic             do_pop;

    // Pop-side view and handshake qualification
    always_comb begin
        push_entry = {push_pc, push_instr, push_bp_state, push_pred_taken};
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(DEPTH));
        push_ready = !full;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass     = empty && !flush && push_valid;
        pop_valid  = !empty || bypass;
        head_sel   = empty ? push_entry : mem_q[rd_ptr_q];
`else
        bypass     = 1'b0;
        pop_valid  = !empty;
        head_sel   = mem_q[rd_ptr_q];
`endif
        pop_entry  = pop_valid ? head_sel : '0;
        // A bypassed entry taken by decode this cycle is never stored
        do_push    = push_valid && push_ready && !(bypass && pop_ready);
        do_pop     = pop_valid && pop_ready && !bypass;
    end

    assign {pop_pc, pop_instr, pop_bp_state, pop_pred_taken} = pop_entry;
    assign count = count_q;

    // Next pointer/occupancy state; flush discards everything including this cycle's push
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed + random bench for fetch_buffer, checked against a queue-based model.
module tb_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [1:0]      bp;
        logic            pt;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst, push_valid, push_ready, pop_valid, pop_ready, flush;
    logic [XLEN-1:0] push_pc, push_instr, pop_pc, pop_instr;
    logic [1:0]      push_bp_state, pop_bp_state;
    logic            push_pred_taken, pop_pred_taken;
    logic [2:0]      count;

    int     n_checks = 0;
    int     n_errors = 0;
    entry_t q[$];

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc(push_pc), .push_instr(push_instr),
        .push_bp_state(push_bp_state), .push_pred_taken(push_pred_taken),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_pc(pop_pc), .pop_instr(pop_instr),
        .pop_bp_state(pop_bp_state), .pop_pred_taken(pop_pred_taken),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_push(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                            input logic [1:0] bp, input logic pt);
        push_valid = v; push_pc = pc; push_instr = ins; push_bp_state = bp; push_pred_taken = pt;
    endtask

    function automatic entry_t cur_push();
        entry_t e;
        e.pc = push_pc; e.instr = push_instr; e.bp = push_bp_state; e.pt = push_pred_taken;
        return e;
    endfunction

    function automatic logic bypass_now();
`ifdef FETCH_BUFFER_BYPASS_EN
        return (q.size() == 0) && push_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against the model's view of the current cycle
    task automatic check_outputs(input string tag);
        logic   ev;
        entry_t ee;
        if (q.size() != 0) begin
            ev = 1'b1; ee = q[0];
        end else if (bypass_now()) begin
            ev = 1'b1; ee = cur_push();
        end else begin
            ev = 1'b0; ee = '0;
        end
        check({tag, ".count"},      64'(count),          64'(q.size()));
        check({tag, ".push_ready"}, 64'(push_ready),     64'(q.size() != DEPTH));
        check({tag, ".pop_valid"},  64'(pop_valid),      64'(ev));
        check({tag, ".pop_pc"},     64'(pop_pc),         64'(ee.pc));
        check({tag, ".pop_instr"},  64'(pop_instr),      64'(ee.instr));
        check({tag, ".pop_bp"},     64'(pop_bp_state),   64'(ee.bp));
        check({tag, ".pop_pt"},     64'(pop_pred_taken), 64'(ee.pt));
    endtask

    // Check, clock once, then apply the FIFO rules to the model
    task automatic cycle(input string tag);
        logic byp;
        logic do_pop;
        logic do_push;
        check_outputs(tag);
        byp     = bypass_now();
        do_pop  = (q.size() != 0) && pop_ready;
        do_push = push_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else if (!(byp && pop_ready)) begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(cur_push());
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pop_ready = 1'b0;
        set_push(1'b0, '0, '0, 2'b00, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        q.delete();
        rst = 1'b0;
        check_outputs("reset");

        // Fill to full, then a rejected fifth push
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, XLEN'(i * 4), XLEN'(32'h13 + i), 2'(i), 1'(i));
            cycle("fill");
        end
        set_push(1'b1, 32'h10, 32'hdead, 2'b11, 1'b1);
        cycle("full_reject");
        check("full_count", 64'(count), 64'd4);

        // Drain in order
        set_push(1'b0, '0, '0, 2'b00, 1'b0);
        pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(pop_pc), 64'(i * 4));
            cycle("drain");
        end
        cycle("drained");

        // Steady-state push+pop at count 2 with pointer wrap
        pop_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1, XLEN'(32'h200 + i * 4), XLEN'($urandom), 2'($urandom), 1'($urandom));
            cycle("pre2");
        end
        pop_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            set_push(1'b1, XLEN'(32'h200 + i * 4), XLEN'($urandom), 2'($urandom), 1'($urandom));
            check("stream_pc", 64'(pop_pc), 64'(32'h200 + (i - 2) * 4));
            cycle("stream");
        end
        check("stream_count", 64'(count), 64'd2);

        // Flush at count 3 drops the same-cycle push
        pop_ready = 1'b0;
        set_push(1'b1, 32'h300, 32'h1, 2'b01, 1'b0);
        cycle("pre_flush");
        set_push(1'b1, 32'h40, 32'h2, 2'b10, 1'b1);
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        set_push(1'b0, '0, '0, 2'b00, 1'b0);
        pop_ready = 1'b1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_pv", 64'(pop_valid), 64'd0);
        cycle("post_flush");

        // Single entry from empty with decode ready
        set_push(1'b1, 32'h100, 32'h00500093, 2'b10, 1'b1);
        cycle("lat_push");
        set_push(1'b0, '0, '0, 2'b00, 1'b0);
`ifdef FETCH_BUFFER_BYPASS_EN
        check("byp_count", 64'(count), 64'd0);
`else
        check("lat_pc", 64'(pop_pc), 64'h100);
        check("lat_instr", 64'(pop_instr), 64'h00500093);
`endif
        cycle("lat_pop");

        // Reset with count 3 and a push pending
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, XLEN'(32'h500 + i * 4), XLEN'($urandom), 2'($urandom), 1'($urandom));
            cycle("pre_rst");
        end
        set_push(1'b1, 32'h600, 32'h7, 2'b01, 1'b1);
        rst = 1'b1;
        cycle("rst_hold");
        rst = 1'b0;
        set_push(1'b0, '0, '0, 2'b00, 1'b0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pr", 64'(push_ready), 64'd1);
        check("rst_pv", 64'(pop_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_push(1'($urandom_range(0, 2) != 0), XLEN'($urandom), XLEN'($urandom),
                     2'($urandom), 1'($urandom));
            pop_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            cycle("rand");
        end
        rst = 1'b0; flush = 1'b0;
        set_push(1'b0, '0, '0, 2'b00, 1'b0);
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
